hazard_sequencer: RTL
=====================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline sequencing unit for the 5-stage RV32 core; sits beside the ID-stage decoder.
//  Detects load-use hazards (stall one cycle), squashes wrong-path work on a taken branch
//  resolved in EX, and drains/halts the pipe on the HALT opcode (7'b1110101).
//  Drives PC/IF-ID write enables and IF-ID / ID-EX flush; keeps saturating stall/flush counters.
// PARAMETERS
//  OPC_W        7   opcode width
//  REG_W        5   register-address width
//  DRAIN_CYCLES 3   cycles after HALT leaves ID until the pipe is empty (EX,MEM,WB)
//  CNT_W        16  width of performance counters
// PORTS
//  clk            in   1      core clock, all state on rising edge
//  reset          in   1      asynchronous, active-low; clears all state
//  id_opcode      in   OPC_W  opcode of instruction in IF/ID
//  id_rs1         in   REG_W  rs1 field of IF/ID instruction
//  id_rs2         in   REG_W  rs2 field of IF/ID instruction
//  ex_memread     in   1      ID/EX holds a load
//  ex_rd          in   REG_W  destination register of ID/EX instruction
//  ex_branch_taken in  1      branch in EX resolved taken this cycle
//  resume         in   1      one-cycle pulse: leave HALTED
//  pc_write       out  1      1: PC register loads next PC
//  if_id_write    out  1      1: IF/ID register loads
//  if_id_flush    out  1      1: IF/ID loaded with NOP (overrides if_id_write)
//  id_ex_flush    out  1      1: ID/EX control fields zeroed (bubble)
//  halted         out  1      core stopped, pipe empty
//  stall_cnt      out  CNT_W  load-use stall cycles, saturating
//  flush_cnt      out  CNT_W  taken-branch flushes, saturating
// BEHAVIOUR
//  - Reset: state=RUN, drain_cnt=0, stall_cnt=0, flush_cnt=0, halted=0. Control outputs are
//    combinational from state+inputs; during reset they evaluate as RUN.
//  - uses_rs1: opcode in {0110011,0000011,0100011,1100011,0010011}; uses_rs2: {0110011,0100011,1100011}.
//  - load_use = ex_memread & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
//  - FSM states RUN, DRAIN, HALTED. Priority in RUN: branch > load_use > halt > normal.
//  - RUN, ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1;
//    flush_cnt++. Any load_use/HALT in ID is discarded (wrong path).
//  - RUN, load_use: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1; stall_cnt++.
//    Exactly one bubble per hazard (next cycle ex_memread=0).
//  - RUN, id_opcode==HALT: pc_write=0, if_id_write=0, id_ex_flush=1; drain_cnt<=DRAIN_CYCLES-1;
//    next state DRAIN. HALT itself never enters EX.
//  - RUN, otherwise: pc_write=1, if_id_write=1, flushes 0.
//  - DRAIN: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1; drain_cnt--; when
//    drain_cnt==0 next state HALTED. ex_branch_taken ignored (cannot occur legally).
//  - HALTED: halted=1; same enables as DRAIN. resume=1: if_id_flush=1, pc_write=1,
//    id_ex_flush=1, next state RUN (fetch restarts at PC = HALT addr + 4). resume outside
//    HALTED ignored.
//  - DRAIN_CYCLES==1: RUN->DRAIN for one cycle then HALTED. DRAIN_CYCLES==0 illegal.
//  - Counters saturate at all-ones, never wrap; counted only on the cycle the event acts.
//  - Reset asserted mid-DRAIN/HALTED: immediately RUN, counters cleared.
//  - halted is a registered output (state==HALTED); asserts DRAIN_CYCLES+1 cycles after HALT in ID.
// TESTING
//  1 lw x5 in EX, add x6,x5,x1 in ID -> one cycle pc_write=0,if_id_write=0,id_ex_flush=1; stall_cnt=1.
//  2 lw x0 in EX, add uses x0; and lw x5 in EX, addi using only rs1=x2 with rs2 field=5 -> no stall.
//  3 ex_branch_taken=1 with load_use true in same cycle -> flushes=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
//  4 HALT in ID, DRAIN_CYCLES=3 -> pc_write=0 from that cycle, halted=1 four cycles later, stays until resume.
//  5 resume pulse in HALTED -> one cycle if_id_flush=1,pc_write=1; state RUN; reset low mid-DRAIN -> RUN, counters 0.
//  6 force 2^CNT_W+5 load-use stalls -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Handshake bundle between the ID-stage sequencer and the rest of the pipeline.
// The slave side is the sequencer; the master side is the pipeline/datapath.
interface hazard_sequencer_if #(
  parameter int OPC_W = 7,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [OPC_W-1:0] id_opcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             resume;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, resume,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, resume,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// ID-stage sequencer: load-use stall, taken-branch squash, HALT drain/resume,
// with saturating stall/flush event counters.
module hazard_sequencer #(
  parameter int OPC_W        = 7,
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              reset,
  hazard_sequencer_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7'b1110101);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          uses_rs1, uses_rs2, load_use;
  logic          stall_inc, flush_inc;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.id_opcode)
      OPC_W'(7'b0110011), OPC_W'(7'b0100011), OPC_W'(7'b1100011): begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_W'(7'b0000011), OPC_W'(7'b0010011): uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = bus.ex_memread && (bus.ex_rd != '0) &&
                    ((uses_rs1 && bus.ex_rd == bus.id_rs1) ||
                     (uses_rs2 && bus.ex_rd == bus.id_rs2));

  always_comb begin
    state_nxt       = state;
    drain_nxt       = drain_cnt;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    bus.pc_write    = 1'b0;
    bus.if_id_write = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b1;
    case (state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          // wrong-path ID contents (hazard or HALT) are discarded
          bus.pc_write    = 1'b1;
          bus.if_id_write = 1'b1;
          bus.if_id_flush = 1'b1;
          flush_inc       = 1'b1;
        end else if (load_use) begin
          stall_inc = 1'b1;
        end else if (bus.id_opcode == OP_HALT) begin
          drain_nxt = DW'(DRAIN_CYCLES - 1);
          state_nxt = DRAIN;
        end else begin
          bus.pc_write    = 1'b1;
          bus.if_id_write = 1'b1;
          bus.id_ex_flush = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = HALTED;
        else                 drain_nxt = drain_cnt - 1'b1;
      end
      HALTED: begin
        if (bus.resume) begin
          bus.pc_write    = 1'b1;
          bus.if_id_flush = 1'b1;
          state_nxt       = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.halted = (state == HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 1'b1;
      if (flush_inc && bus.flush_cnt != '1) bus.flush_cnt <= bus.flush_cnt + 1'b1;
    end
  end
endmodule
